// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the integer register file.
//   XLEN_DEF / NREGS_DEF : default register width and register count
//   reg_addr_t           : register address type at the default size
//   ZERO_REG             : address of the hard-wired zero register
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_busy_tracker.sv
// regfile_busy_tracker: pending-write scoreboard for the register file.
// Holds one busy bit per register, decides whether a reservation is
// accepted, applies flush, and keeps an incremental count of busy bits.
// Ports:
//   clock, reset        clock (rising edge), asynchronous active-low reset
//   wr_en, wr_addr      writeback strobe / address (clears busy)
//   rsv_en, rsv_addr    reservation request / destination (sets busy)
//   flush               clears every busy bit on the edge
//   busy                current busy vector (bit 0 is always 0)
//   rsv_ok              reservation accepted this cycle (combinational)
//   busy_count          registered popcount of busy
module regfile_busy_tracker
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = $clog2(NREGS)   // derived from NREGS
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          rsv_en,
   input  logic [AW-1:0] rsv_addr,
   input  logic          flush,
   output logic [NREGS-1:0] busy,
   output logic          rsv_ok,
   output logic [AW:0]   busy_count
);

   logic [NREGS-1:0] busy_next;
   logic [AW:0]      count_next;
   logic             set_hit;
   logic             clr_hit;
   logic             inc;
   logic             dec;

   // A same-cycle writeback to the reserved register retires the old
   // producer, so the new reservation may take its place.
   assign rsv_ok = (rsv_addr == '0) || !busy[rsv_addr] ||
                   (wr_en && (wr_addr == rsv_addr));

   // Flush suppresses the reservation entirely; the new producer wins over
   // a writeback to the same register.
   assign set_hit = rsv_en && rsv_ok && (rsv_addr != '0) && !flush;
   assign clr_hit = wr_en && (wr_addr != '0) &&
                    !(set_hit && (wr_addr == rsv_addr));

   // Net count change: a set of an already-busy bit only happens when the
   // same register is being written, so it is a no-op for the count.
   assign inc = set_hit && !busy[rsv_addr];
   assign dec = clr_hit && busy[wr_addr];

   always_comb begin
      busy_next = busy;
      if (clr_hit) busy_next[wr_addr] = 1'b0;
      if (set_hit) busy_next[rsv_addr] = 1'b1;
      if (flush)   busy_next = '0;
   end

   always_comb begin
      count_next = busy_count + (AW+1)'(inc) - (AW+1)'(dec);
      if (flush) count_next = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_next;
         busy_count <= count_next;
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two combinational read ports,
// optional same-cycle write bypass, and a pending-write scoreboard.
// Register 0 reads as zero, ignores writes and is never busy.
// Ports:
//   clock, reset            clock (rising edge), asynchronous active-low reset
//   rs1_addr / rs2_addr     read addresses
//   rs1_data / rs2_data     read data (combinational)
//   rs1_busy / rs2_busy     addressed register has a pending producer
//   wr_en, wr_addr, wr_data writeback port
//   rsv_en, rsv_addr        reserve a destination for a long-latency op
//   rsv_ok                  reservation accepted (combinational)
//   flush                   clear all busy bits on the edge
//   stall                   decode must stall this cycle
//   busy_count              registered number of busy registers
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = XLEN_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter int AW     = $clog2(NREGS),   // derived from NREGS
   parameter int BYPASS = 1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] rs2_data,
   output logic            rs1_busy,
   output logic            rs2_busy,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   input  logic            rsv_en,
   input  logic [AW-1:0]   rsv_addr,
   output logic            rsv_ok,
   input  logic            flush,
   output logic            stall,
   output logic [AW:0]     busy_count
);

   localparam bit BYP = (BYPASS != 0);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic             wr_live;
   logic             byp1;
   logic             byp2;

   regfile_busy_tracker #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_busy (
      .clock      (clock),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .flush      (flush),
      .busy       (busy),
      .rsv_ok     (rsv_ok),
      .busy_count (busy_count)
   );

   // regs[0] is never written, so it stays at its reset value of zero.
   assign wr_live = wr_en && (wr_addr != '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign byp1 = BYP && wr_live && (wr_addr == rs1_addr);
   assign byp2 = BYP && wr_live && (wr_addr == rs2_addr);

   assign rs1_data = byp1 ? wr_data : regs[rs1_addr];
   assign rs2_data = byp2 ? wr_data : regs[rs2_addr];

   // busy[0] is always clear, so address 0 needs no special case here.
   assign rs1_busy = busy[rs1_addr] && !byp1;
   assign rs2_busy = busy[rs2_addr] && !byp2;

   assign stall = rs1_busy || rs2_busy || (rsv_en && !rsv_ok);

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREGS = 32;
   localparam int AW = 5;

   logic            clock;
   logic            reset;
   logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr;
   logic            wr_en, rsv_en, flush;
   logic [XLEN-1:0] wr_data;

   logic [XLEN-1:0] rs1_data, rs2_data;
   logic            rs1_busy, rs2_busy, rsv_ok, stall;
   logic [AW:0]     busy_count;

   logic [XLEN-1:0] nb_rs1_data, nb_rs2_data;
   logic            nb_rs1_busy, nb_rs2_busy, nb_rsv_ok, nb_stall;
   logic [AW:0]     nb_busy_count;

   int n_cmp = 0;
   int n_fail = 0;

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) u_dut (
      .clock(clock), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
      .flush(flush), .stall(stall), .busy_count(busy_count)
   );

   regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) u_nb (
      .clock(clock), .reset(reset),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
      .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
      .flush(flush), .stall(nb_stall), .busy_count(nb_busy_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic idle();
      wr_en = 0; wr_addr = '0; wr_data = '0;
      rsv_en = 0; rsv_addr = '0; flush = 0;
   endtask

   task automatic next_cycle();
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      reset = 0; idle(); rs1_addr = '0; rs2_addr = '0;
      #2;
      n_cmp++; if (busy_count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", busy_count); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
      for (int a = 0; a < NREGS; a++) begin
         rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a); #1;
         n_cmp++; if (rs1_data !== 0 || rs2_data !== 0) begin n_fail++; $display("FAIL reset_data[%0d]: got %h/%h want 0", a, rs1_data, rs2_data); end
         n_cmp++; if (rs1_busy !== 0 || rs2_busy !== 0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b/%b want 0", a, rs1_busy, rs2_busy); end
      end
      @(negedge clock); reset = 1;
   endtask

   task automatic test_write_bypass();
      @(negedge clock); idle();
      wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5; rs2_addr = 0;
      #1;
      n_cmp++; if (rs1_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_x5: got %h want deadbeef", rs1_data); end
      @(negedge clock);
      wr_en = 1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0; rs2_addr = 5;
      #1;
      n_cmp++; if (rs1_data !== 0) begin n_fail++; $display("FAIL x0_bypass: got %h want 0", rs1_data); end
      n_cmp++; if (rs2_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL x5_stored: got %h want deadbeef", rs2_data); end
      @(negedge clock); idle(); #1;
      n_cmp++; if (rs1_data !== 0) begin n_fail++; $display("FAIL x0_after_write: got %h want 0", rs1_data); end
   endtask

   task automatic test_reserve_write();
      @(negedge clock); idle();
      rsv_en = 1; rsv_addr = 7; rs1_addr = 0; rs2_addr = 7;
      #1;
      n_cmp++; if (rsv_ok !== 1 || rs2_busy !== 0) begin n_fail++; $display("FAIL rsv7_accept: got ok=%b busy=%b want ok=1 busy=0", rsv_ok, rs2_busy); end
      @(negedge clock); idle(); #1;
      n_cmp++; if (rs2_busy !== 1) begin n_fail++; $display("FAIL x7_busy: got %b want 1", rs2_busy); end
      n_cmp++; if (stall !== 1) begin n_fail++; $display("FAIL x7_stall: got %b want 1", stall); end
      n_cmp++; if (busy_count !== 1) begin n_fail++; $display("FAIL x7_count: got %0d want 1", busy_count); end
      wr_en = 1; wr_addr = 7; wr_data = 32'h55; #1;
      n_cmp++; if (rs2_busy !== 0 || rs2_data !== 32'h55) begin n_fail++; $display("FAIL x7_wb_bypass: got busy=%b data=%h want 0/55", rs2_busy, rs2_data); end
      n_cmp++; if (stall !== 0) begin n_fail++; $display("FAIL x7_wb_stall: got %b want 0", stall); end
      next_cycle();
      n_cmp++; if (busy_count !== 0) begin n_fail++; $display("FAIL x7_count_clear: got %0d want 0", busy_count); end
   endtask

   task automatic test_waw();
      @(negedge clock); idle();
      rsv_en = 1; rsv_addr = 3; rs1_addr = 0; rs2_addr = 0;
      @(negedge clock); #1;
      n_cmp++; if (rsv_ok !== 0 || stall !== 1) begin n_fail++; $display("FAIL waw_reject: got ok=%b stall=%b want 0/1", rsv_ok, stall); end
      next_cycle();
      n_cmp++; if (busy_count !== 1) begin n_fail++; $display("FAIL waw_count: got %0d want 1", busy_count); end
      @(negedge clock);
      rsv_en = 1; rsv_addr = 3; wr_en = 1; wr_addr = 3; wr_data = 32'hABC; #1;
      n_cmp++; if (rsv_ok !== 1 || stall !== 0) begin n_fail++; $display("FAIL rsv_wr_same: got ok=%b stall=%b want 1/0", rsv_ok, stall); end
      @(negedge clock); idle(); rs1_addr = 3; #1;
      n_cmp++; if (rs1_data !== 32'hABC || rs1_busy !== 1) begin n_fail++; $display("FAIL rsv_wr_result: got data=%h busy=%b want abc/1", rs1_data, rs1_busy); end
      n_cmp++; if (busy_count !== 1) begin n_fail++; $display("FAIL rsv_wr_count: got %0d want 1", busy_count); end
      wr_en = 1; wr_addr = 3; wr_data = 32'h3; next_cycle();
      n_cmp++; if (busy_count !== 0) begin n_fail++; $display("FAIL x3_release: got %0d want 0", busy_count); end
   endtask

   task automatic test_flush();
      @(negedge clock); idle(); rsv_en = 1; rsv_addr = 1;
      @(negedge clock); rsv_addr = 2;
      @(negedge clock); rsv_addr = 4;
      @(negedge clock); idle(); #1;
      n_cmp++; if (busy_count !== 3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", busy_count); end
      flush = 1; rsv_en = 1; rsv_addr = 6; #1;
      n_cmp++; if (rsv_ok !== 1) begin n_fail++; $display("FAIL flush_rsv_ok: got %b want 1", rsv_ok); end
      @(negedge clock); idle(); rs1_addr = 6; rs2_addr = 1; #1;
      n_cmp++; if (busy_count !== 0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", busy_count); end
      n_cmp++; if (rs1_busy !== 0 || rs2_busy !== 0) begin n_fail++; $display("FAIL flush_busy_6_1: got %b/%b want 0/0", rs1_busy, rs2_busy); end
      rs1_addr = 2; rs2_addr = 4; #1;
      n_cmp++; if (rs1_busy !== 0 || rs2_busy !== 0) begin n_fail++; $display("FAIL flush_busy_2_4: got %b/%b want 0/0", rs1_busy, rs2_busy); end
   endtask

   task automatic test_async_reset();
      @(negedge clock); idle(); rsv_en = 1; rsv_addr = 9;
      @(negedge clock); idle(); rs1_addr = 9; rs2_addr = 5; #1;
      n_cmp++; if (rs1_busy !== 1 || busy_count !== 1 || rs2_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset: got busy=%b cnt=%0d x5=%h want 1/1/deadbeef", rs1_busy, busy_count, rs2_data); end
      #1 reset = 0; #1;
      n_cmp++; if (rs1_busy !== 0 || busy_count !== 0) begin n_fail++; $display("FAIL async_reset_busy: got busy=%b cnt=%0d want 0/0", rs1_busy, busy_count); end
      n_cmp++; if (rs2_data !== 0) begin n_fail++; $display("FAIL async_reset_data: got %h want 0", rs2_data); end
      @(negedge clock); reset = 1;
   endtask

   task automatic test_no_bypass();
      @(negedge clock); idle();
      wr_en = 1; wr_addr = 10; wr_data = 32'hCAFE; rs1_addr = 10; rs2_addr = 0; #1;
      n_cmp++; if (nb_rs1_data !== 0) begin n_fail++; $display("FAIL nb_same_cycle: got %h want 0", nb_rs1_data); end
      n_cmp++; if (rs1_data !== 32'hCAFE) begin n_fail++; $display("FAIL byp_same_cycle: got %h want cafe", rs1_data); end
      @(negedge clock); idle(); #1;
      n_cmp++; if (nb_rs1_data !== 32'hCAFE) begin n_fail++; $display("FAIL nb_next_cycle: got %h want cafe", nb_rs1_data); end
      rsv_en = 1; rsv_addr = 11;
      @(negedge clock); idle(); rs1_addr = 11;
      wr_en = 1; wr_addr = 11; wr_data = 32'h77; #1;
      n_cmp++; if (nb_rs1_busy !== 1 || nb_stall !== 1) begin n_fail++; $display("FAIL nb_busy_same: got busy=%b stall=%b want 1/1", nb_rs1_busy, nb_stall); end
      @(negedge clock); idle(); #1;
      n_cmp++; if (nb_rs1_busy !== 0 || nb_rs1_data !== 32'h77 || nb_busy_count !== 0) begin n_fail++; $display("FAIL nb_busy_next: got busy=%b data=%h cnt=%0d want 0/77/0", nb_rs1_busy, nb_rs1_data, nb_busy_count); end
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_reserve_write();
      test_waw();
      test_flush();
      test_async_reset();
      test_no_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with a built-in pending-write scoreboard, for the RISC-V core's decode/writeback boundary. It holds XLEN-bit architectural registers with register 0 hard-wired to zero. It provides two combinational read ports with optional same-cycle write bypass. A busy bit per register tracks outstanding multi-cycle producers (loads, divides), so decode can detect RAW/WAW hazards and stall.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of registers; power of two, ≥ 2
- AW, $clog2(NREGS), address width (derived, not overridden)
- BYPASS, 1, 1 = same-cycle write data and busy-clear visible on read ports; 0 = visible next cycle

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- rs1_busy, rs2_busy  out  1  addressed register has a pending producer
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- rsv_en  in  1  request to mark rsv_addr pending (issue of a long-latency op)
- rsv_addr  in  AW  destination to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- flush  in  1  synchronous clear of all busy bits
- stall  out  1  rs1_busy | rs2_busy | (rsv_en & ~rsv_ok)
- busy_count  out  AW+1  registered count of set busy bits

## Operation
- Register 0: reads return 0; writes are discarded; it is never busy; reservations of it are accepted (rsv_ok=1) with no effect.
- Write: when wr_en=1 and wr_addr≠0, reg[wr_addr]←wr_data and busy[wr_addr]←0 on the edge, unless a same-cycle accepted reservation targets the same address.
- Read: rsN_data = reg[rsN_addr]. With BYPASS=1, if wr_en & wr_addr==rsN_addr ≠ 0, it returns wr_data instead.
- rsN_busy = busy[rsN_addr] & ~(BYPASS & wr_en & wr_addr==rsN_addr). Reservations never affect the same cycle's busy outputs.
- rsv_ok = (rsv_addr==0) | ~busy[rsv_addr] | (wr_en & wr_addr==rsv_addr). A reservation of an already-busy register (WAW) is rejected: state is unchanged and stall=1.
- Accepted reservation with rsv_addr≠0 sets busy[rsv_addr] on the edge.
- Reservation and write to the same address in one cycle: data is written and busy ends at 1, because the new producer wins.
- flush=1: all busy bits clear on the edge. This overrides a same-cycle reservation, which is not recorded. Writes still happen. rsv_ok is still computed normally.
- busy_count always equals the popcount of the busy vector after each edge. It is maintained incrementally (+1 set, −1 clear, net of simultaneous events), and flush forces it to 0.

## Timing
- Reset (asynchronous assert, released synchronously by the system): all registers 0, all busy bits 0, busy_count 0. Outputs follow immediately: rsN_data=0, rsN_busy=0, stall=0 if rsv_en=0.
- Read latency is 0 cycles (combinational).
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0.
- Reservation is visible on rsN_busy one cycle after acceptance.
- Busy clear by writeback: same cycle with BYPASS=1, next cycle otherwise.
- Reset asserted mid-operation discards all pending reservations and data. There is no partial state.

## Structure
- Shared package regfile_pkg: default XLEN and NREGS constants, the reg_addr_t typedef, and the ZERO_REG constant.
- Sub-module regfile_busy_tracker: busy vector, rsv_ok logic, flush, and busy_count. The top level holds the data array, read muxes and bypass.

## Test plan
- Reset, then read all addresses → every rsN_data=0, rsN_busy=0, busy_count=0.
- Write 0xDEADBEEF to x5 with rs1_addr=5, BYPASS=1 → rs1_data=0xDEADBEEF in the same cycle. Write 0x1234 to x0 → reading x0 still returns 0.
- Reserve x7 → next cycle rs2_addr=7 gives rs2_busy=1, stall=1, busy_count=1. Write x7=0x55 → same cycle rs2_busy=0 and data=0x55; next cycle busy_count=0.
- Reserve x3 twice (x3 still busy) → second request gives rsv_ok=0, stall=1, busy_count stays 1. Reserve and write x3 in the same cycle → rsv_ok=1, data updated, x3 still busy, busy_count=1.
- Reserve x1, x2, x4, then assert flush together with a reserve of x6 → next cycle all busy=0, busy_count=0, and x6 is not busy.
- Reserve x9, then assert reset asynchronously between clock edges → busy and data clear immediately. With BYPASS=0, a write followed by a same-cycle read returns the old value, and the new value the next cycle.
